// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_pkg
// Brief  : Shared op-code constants for the registered bitwise logic unit.
// Rev    : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

    localparam int LU_OP_W = 3;

    localparam logic [LU_OP_W-1:0] LU_AND  = 3'd0;
    localparam logic [LU_OP_W-1:0] LU_OR   = 3'd1;
    localparam logic [LU_OP_W-1:0] LU_XOR  = 3'd2;
    localparam logic [LU_OP_W-1:0] LU_NAND = 3'd3;
    localparam logic [LU_OP_W-1:0] LU_NOR  = 3'd4;
    localparam logic [LU_OP_W-1:0] LU_XNOR = 3'd5;
    localparam logic [LU_OP_W-1:0] LU_NOT  = 3'd6;
    localparam logic [LU_OP_W-1:0] LU_PASS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/logic_op_core.sv
`default_nettype none
// ============================================================================
// Module : logic_op_core
// Brief  : Combinational bitwise operator with zero/all-ones/parity flags.
// Rev    : 1.0  initial release
// ============================================================================
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [LU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               ones,
    output logic               par
);

    always_comb begin
        y = '0;
        case (op)
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_XOR:  y = a ^ b;
            LU_NAND: y = ~(a & b);
            LU_NOR:  y = ~(a | b);
            LU_XNOR: y = ~(a ^ b);
            LU_NOT:  y = ~a;
            LU_PASS: y = a;
            default: y = a;
        endcase
    end

    assign zero = ~|y;
    assign ones = &y;
    assign par  = ^y;

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_pipe
// Brief  : Registered logic unit with valid/ready handshake and 2-entry skid.
// Rev    : 1.0  initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic               out_zero,
    output logic               out_ones,
    output logic               out_par
);

    logic [WIDTH-1:0] w_y;
    logic             w_zero;
    logic             w_ones;
    logic             w_par;
    logic             w_in_xfer;
    logic             w_main_free;

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_y;
    logic             r_main_zero;
    logic             r_main_ones;
    logic             r_main_par;

    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_y;
    logic             r_skid_zero;
    logic             r_skid_ones;
    logic             r_skid_par;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op   (in_op),
        .a    (in_a),
        .b    (in_b),
        .y    (w_y),
        .zero (w_zero),
        .ones (w_ones),
        .par  (w_par)
    );

    assign w_in_xfer   = in_valid && in_ready;
    assign w_main_free = !r_main_valid || out_ready;

    // Skid is only ever filled while main is occupied, so an empty main implies an empty skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_y     <= '0;
            r_main_zero  <= 1'b1;
            r_main_ones  <= 1'b0;
            r_main_par   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_y     <= '0;
            r_skid_zero  <= 1'b1;
            r_skid_ones  <= 1'b0;
            r_skid_par   <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_y     <= r_skid_y;
                r_main_zero  <= r_skid_zero;
                r_main_ones  <= r_skid_ones;
                r_main_par   <= r_skid_par;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main_valid <= 1'b1;
                r_main_y     <= w_y;
                r_main_zero  <= w_zero;
                r_main_ones  <= w_ones;
                r_main_par   <= w_par;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_y     <= w_y;
            r_skid_zero  <= w_zero;
            r_skid_ones  <= w_ones;
            r_skid_par   <= w_par;
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_y     = r_main_y;
    assign out_zero  = r_main_zero;
    assign out_ones  = r_main_ones;
    assign out_par   = r_main_par;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_logic_unit_pipe
// Brief  : Self-checking bench for logic_unit_pipe against a depth-2 FIFO model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
    logic       out_par;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       o;
        logic       p;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain arithmetic: complement is 255 minus the value.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   y;
        case (op)
            3'd0:    y = int'(a & b);
            3'd1:    y = int'(a | b);
            3'd2:    y = int'(a ^ b);
            3'd3:    y = 255 - int'(a & b);
            3'd4:    y = 255 - int'(a | b);
            3'd5:    y = 255 - int'(a ^ b);
            3'd6:    y = 255 - int'(a);
            default: y = int'(a);
        endcase
        e.y = y[7:0];
        e.z = (y == 0);
        e.o = (y == 255);
        e.p = ($countones(y) % 2) == 1;
        return e;
    endfunction

    // One clock cycle: drive inputs, check outputs against the FIFO model, advance.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy, output logic accepted);
        int occ;
        occ       = q.size();
        in_valid  = v;
        in_op     = v ? op : 3'bxxx;
        in_a      = v ? a : 8'hxx;
        in_b      = v ? b : 8'hxx;
        out_ready = rdy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
        if (occ > 0) begin
            chk("out_y", {24'd0, out_y}, {24'd0, q[0].y});
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0].z});
            chk("out_ones", {31'd0, out_ones}, {31'd0, q[0].o});
            chk("out_par", {31'd0, out_par}, {31'd0, q[0].p});
        end
        accepted = v && (occ < 2);
        if (occ > 0 && rdy) void'(q.pop_front());
        if (accepted) q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_y"}, {24'd0, out_y}, 32'd0);
        chk({tag, "_out_zero"}, {31'd0, out_zero}, 32'd1);
        chk({tag, "_out_ones"}, {31'd0, out_ones}, 32'd0);
        chk({tag, "_out_par"}, {31'd0, out_par}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [7:0] sweep_tbl [8];
    logic       acc;

    initial begin
        sweep_tbl = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A, 8'hA5};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Op sweep: each result appears one cycle after its accept.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 8'hA5, 8'h3C, 1'b1, acc);
            chk("sweep_y", {24'd0, out_y}, {24'd0, sweep_tbl[i]});
            chk("sweep_par", {31'd0, out_par}, 32'd0);
        end
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);

        // Flag corners
        cycle(1'b1, 3'd0, 8'hFF, 8'h00, 1'b1, acc);
        chk("flag_and_zero", {31'd0, out_zero}, 32'd1);
        cycle(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b1, acc);
        chk("flag_or_ones", {31'd0, out_ones}, 32'd1);
        chk("flag_or_y", {24'd0, out_y}, 32'hFF);
        cycle(1'b1, 3'd7, 8'h01, 8'h00, 1'b1, acc);
        chk("flag_pass_par", {31'd0, out_par}, 32'd1);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);

        // Backpressure: third beat must wait for the skid to drain.
        cycle(1'b1, 3'd7, 8'h11, 8'h00, 1'b0, acc);
        cycle(1'b1, 3'd7, 8'h22, 8'h00, 1'b0, acc);
        chk("bp_hold_y", {24'd0, out_y}, 32'h11);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 3'd7, 8'h33, 8'h00, 1'b0, acc);
        chk("bp_33_waits", {31'd0, acc}, 32'd0);
        chk("bp_still_11", {24'd0, out_y}, 32'h11);
        cycle(1'b1, 3'd7, 8'h33, 8'h00, 1'b1, acc);
        chk("bp_22_next", {24'd0, out_y}, 32'h22);
        cycle(1'b1, 3'd7, 8'h33, 8'h00, 1'b1, acc);
        chk("bp_33_taken", {31'd0, acc}, 32'd1);
        chk("bp_33_out", {24'd0, out_y}, 32'h33);
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Throughput: one XOR result per cycle.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 3'd2, 8'(i), 8'hFF, 1'b1, acc);
            chk("thru_y", {24'd0, out_y}, {24'd0, 8'(255 - i)});
            chk("thru_in_ready", {31'd0, in_ready}, 32'd1);
        end
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);

        // Random stall against the FIFO scoreboard.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 99) < 55), acc);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
        chk("rand_drained", q.size(), 32'd0);

        // Reset mid-flight with both registers full and a beat on the input.
        cycle(1'b1, 3'd7, 8'h77, 8'h00, 1'b0, acc);
        cycle(1'b1, 3'd7, 8'h88, 8'h00, 1'b0, acc);
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_op     = 3'd7;
        in_a      = 8'h99;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check_reset_state("midrst");
        cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
        chk("midrst_no_beat", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
